// File: rtl/powlib_syncfilt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : powlib_syncfilt_pkg
// Description : Shared powlib helper functions used to size the glitch-filter
//               counters of powlib_syncfilt.
// Revision    : 1.0 - initial release
// ============================================================================
package powlib_syncfilt_pkg;

  // Ceiling log2 of value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Filter counter width: holds 0..f-1 and is never narrower than one bit.
  function automatic int cnt_width(input int f);
    return (clog2(f) < 1) ? 1 : clog2(f);
  endfunction

endpackage
`default_nettype wire

// File: rtl/powlib_syncfilt_ch.sv
`default_nettype none
// ============================================================================
// Module      : powlib_syncfilt_ch
// Description : One channel: S-stage synchronizer, persistence filter that
//               accepts a new level after F consecutive disagreeing samples,
//               and registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module powlib_syncfilt_ch
  import powlib_syncfilt_pkg::*;
#(
  parameter int   S    = 3,
  parameter int   F    = 4,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_evt
);

  localparam int              c_cw      = cnt_width(F);
  localparam logic [c_cw-1:0] c_cnt_max = c_cw'(F - 1);

  (* ASYNC_REG = "TRUE" *) logic [S-1:0] r_sync;
  logic [c_cw-1:0] r_cnt;
  logic            r_q;
  logic            r_rise;
  logic            r_fall;

  logic w_s;
  logic w_diff;
  logic w_last;
  logic w_evt;

  assign w_s    = r_sync[S-1];
  assign w_diff = w_s ^ r_q;
  assign w_last = (r_cnt == c_cnt_max);
  // q will take the synchronized level at the next edge; the top registers
  // this to produce chg in the same cycle as rise/fall.
  assign w_evt  = w_diff & w_last;

  // Plain shift chain from the asynchronous pin; nothing between stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {S{INIT}};
    end else begin
      r_sync <= {r_sync[S-2:0], i_d};
    end
  end

  // Persistence filter: any agreeing sample discards the partial count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= INIT;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_evt & w_s;
      r_fall <= w_evt & ~w_s;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_last) begin
        r_q   <= w_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_evt  = w_evt;

endmodule
`default_nettype wire

// File: rtl/powlib_syncfilt.sv
`default_nettype none
// ============================================================================
// Module      : powlib_syncfilt
// Description : C-channel asynchronous-input synchronizer with per-channel
//               glitch filter, rise/fall pulses and a combined change flag.
// Revision    : 1.0 - initial release
// ============================================================================
module powlib_syncfilt
  import powlib_syncfilt_pkg::*;
#(
  parameter int           C    = 4,
  parameter int           S    = 3,
  parameter int           F    = 4,
  parameter logic [C-1:0] INIT = {C{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [C-1:0] d,
  output logic [C-1:0] q,
  output logic [C-1:0] rise,
  output logic [C-1:0] fall,
  output logic         chg
);

  if (C < 1) begin : g_chk_c
    $error("powlib_syncfilt: C must be >= 1");
  end
  if (S < 2) begin : g_chk_s
    $error("powlib_syncfilt: S must be >= 2");
  end
  if (F < 1) begin : g_chk_f
    $error("powlib_syncfilt: F must be >= 1");
  end

  logic [C-1:0] w_evt;
  logic         r_chg;

  for (genvar i = 0; i < C; i++) begin : g_ch
    powlib_syncfilt_ch #(
      .S    (S),
      .F    (F),
      .INIT (INIT[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_d    (d[i]),
      .o_q    (q[i]),
      .o_rise (rise[i]),
      .o_fall (fall[i]),
      .o_evt  (w_evt[i])
    );
  end

  // Registered alongside the per-channel pulses so chg lines up with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= |w_evt;
    end
  end

  assign chg = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_powlib_syncfilt.sv
`default_nettype none
// ============================================================================
// Module      : tb_powlib_syncfilt
// Description : Scoreboard bench for powlib_syncfilt (C=4, S=3, F=4,
//               INIT=4'b0101). Stimulus queues each expected q/rise/fall event
//               with its edge number; the monitor pops on every pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_powlib_syncfilt;

  localparam int         C    = 4;
  localparam int         S    = 3;
  localparam int         F    = 4;
  localparam logic [3:0] INIT = 4'b0101;
  localparam int         LAT  = S + F;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] d   = 4'b0000;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       chg;

  typedef struct {
    int         cyc;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
  } evt_t;

  evt_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  powlib_syncfilt #(
    .C    (C),
    .S    (S),
    .F    (F),
    .INIT (INIT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .chg  (chg)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; read on the falling edge by stimulus and monitor.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int at, input logic [3:0] eq, input logic [3:0] er,
                            input logic [3:0] ef);
    evt_t e;
    e.cyc  = at;
    e.q    = eq;
    e.rise = er;
    e.fall = ef;
    sb.push_back(e);
  endtask

  // Change d on the falling edge; k is the edge count, so e0 is edge k+1.
  task automatic drive(input logic [3:0] v, output int k);
    @(negedge clk);
    d = v;
    k = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest queued event and its edge.
  always @(negedge clk) begin
    evt_t e;
    if (rst) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checki("missed_event_edge", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (chg || (rise != 4'b0000) || (fall != 4'b0000)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: q=%b rise=%b fall=%b chg=%b required no event (edge %0d)",
                   q, rise, fall, chg, cyc);
        end else begin
          e = sb.pop_front();
          checki("event_edge", cyc, e.cyc);
          check4("event_q", q, e.q);
          check4("event_rise", rise, e.rise);
          check4("event_fall", fall, e.fall);
          check4("event_chg", {3'b000, chg}, 4'b0001);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int kstart;
    int pat[9];
    pat = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

    // Reset held with d toggling: outputs pinned to INIT, no pulses.
    for (int i = 0; i < 6; i++) begin
      drive(4'($urandom), k);
      @(posedge clk);
      #1;
      check4("reset_q", q, INIT);
      check4("reset_rise", rise, 4'b0000);
      check4("reset_fall", fall, 4'b0000);
      check4("reset_chg", {3'b000, chg}, 4'b0000);
    end
    @(negedge clk);
    d   = INIT;
    rst = 1'b1;
    idle(20);
    check4("q_after_release", q, INIT);

    // Clean steps: ch0 falls, then ch1 rises.
    drive(4'b0100, k);
    expect_evt(k + LAT, 4'b0100, 4'b0000, 4'b0001);
    idle(10);
    drive(4'b0110, k);
    expect_evt(k + LAT, 4'b0110, 4'b0010, 4'b0000);
    idle(10);

    // Glitch on ch3: 2 cycles high is rejected.
    drive(4'b1110, k);
    idle(1);
    drive(4'b0110, k);
    idle(12);
    check4("q_after_glitch", q, 4'b0110);

    // Exactly F cycles high: accepted, then the return low is accepted too.
    drive(4'b1110, k);
    expect_evt(k + LAT, 4'b1110, 4'b1000, 4'b0000);
    idle(3);
    drive(4'b0110, k);
    expect_evt(k + LAT, 4'b0110, 4'b0000, 4'b1000);
    idle(12);

    // Bounce on ch2: drop it first, then bounce up to a stable high.
    drive(4'b0010, k);
    expect_evt(k + LAT, 4'b0010, 4'b0000, 4'b0100);
    idle(10);
    kstart = 0;
    for (int i = 0; i < 9; i++) begin
      drive({1'b0, pat[i][0], 2'b10}, k);
      if (i == 5) kstart = k;
    end
    expect_evt(kstart + LAT, 4'b0110, 4'b0100, 4'b0000);
    idle(12);

    // Simultaneous changes on all channels.
    drive(4'b0000, k);
    expect_evt(k + LAT, 4'b0000, 4'b0000, 4'b0110);
    idle(10);
    drive(4'b1111, k);
    expect_evt(k + LAT, 4'b1111, 4'b1111, 4'b0000);
    idle(10);
    drive(4'b0000, k);
    expect_evt(k + LAT, 4'b0000, 4'b0000, 4'b1111);
    idle(10);

    // Reset mid-transition on ch1 at e(S+1): q jumps to INIT with no pulse.
    drive(4'b0010, k);
    repeat (S + 2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check4("midreset_q", q, INIT);
    check4("midreset_rise", rise, 4'b0000);
    check4("midreset_fall", fall, 4'b0000);
    check4("midreset_chg", {3'b000, chg}, 4'b0000);
    idle(3);
    d   = 4'b0111;
    rst = 1'b1;
    k   = cyc;
    expect_evt(k + LAT, 4'b0111, 4'b0010, 4'b0000);
    idle(12);
    check4("q_final", q, 4'b0111);
    checki("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
